// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: function codes, FSM states,
// bit-slice op codes and the funct -> slice-control decoder.
package serial_alu_pkg;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       ainv;
    logic       binv;
    logic       cin;
    logic [1:0] op;
  } slice_ctrl_t;

  // Don't-care carry-in for and/or/nor is tied to 0.
  function automatic slice_ctrl_t decode_funct(input logic [5:0] f);
    slice_ctrl_t c;
    c.legal = 1'b1;
    c.ainv  = 1'b0;
    c.binv  = 1'b0;
    c.cin   = 1'b0;
    c.op    = OP_SUM;
    case (f)
      FUNCT_ADD: ;
      FUNCT_SUB: begin c.binv = 1'b1; c.cin = 1'b1; end
      FUNCT_AND: c.op = OP_AND;
      FUNCT_OR:  c.op = OP_OR;
      FUNCT_NOR: begin c.ainv = 1'b1; c.binv = 1'b1; c.op = OP_AND; end
      FUNCT_SLT: begin c.binv = 1'b1; c.cin = 1'b1; end
      default:   c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serial_alu_bit_slice.sv
// One-bit ALU slice: optional operand inversion, then AND, OR or full-add.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic [1:0] op,
  output logic       res,
  output logic       cout
);

  logic aa;
  logic bb;

  assign aa   = a ^ ainvert;
  assign bb   = b ^ binvert;
  assign cout = (aa & bb) | (cin & (aa ^ bb));

  always_comb begin
    res = 1'b0;
    case (op)
      OP_AND:  res = aa & bb;
      OP_OR:   res = aa | bb;
      OP_SUM:  res = aa ^ bb ^ cin;
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial R-type ALU: processes one operand bit per cycle, LSB first,
// through a single shared slice; results are published on the done pulse.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [5:0]         funct_q, funct_d;
  logic               ovf_raw_q, ovf_raw_d;
  logic               ill_pend_q, ill_pend_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d, ovf_q, ovf_d, illegal_q, illegal_d, done_q, done_d;

  slice_ctrl_t        ctrl;
  logic               slice_res, slice_cout;
  logic               is_slt, is_addsub, less;
  logic [WIDTH-1:0]   fin_res;

  // In IDLE the live funct is decoded (legality, initial carry); afterwards the captured one.
  assign ctrl = decode_funct((state_q == ST_IDLE) ? funct : funct_q);

  alu_bit_slice u_slice (
    .a       (a_q[0]),
    .b       (b_q[0]),
    .cin     (carry_q),
    .ainvert (ctrl.ainv),
    .binvert (ctrl.binv),
    .op      (ctrl.op),
    .res     (slice_res),
    .cout    (slice_cout)
  );

  assign is_slt    = (funct_q == FUNCT_SLT);
  assign is_addsub = (funct_q == FUNCT_ADD) || (funct_q == FUNCT_SUB);
  assign less      = sum_q[WIDTH-1] ^ ovf_raw_q;
  assign fin_res   = is_slt ? {{(WIDTH-1){1'b0}}, less} : sum_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    funct_d    = funct_q;
    ovf_raw_d  = ovf_raw_q;
    ill_pend_d = ill_pend_q;
    result_d   = result_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    illegal_d  = illegal_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          funct_d    = funct;
          ill_pend_d = ~ctrl.legal;
          if (ctrl.legal) begin
            a_d       = a;
            b_d       = b;
            sum_d     = '0;
            cnt_d     = '0;
            carry_d   = ctrl.cin;
            ovf_raw_d = 1'b0;
            state_d   = ST_RUN;
          end else begin
            state_d   = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {slice_res, sum_q[WIDTH-1:1]};
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          ovf_raw_d = carry_q ^ slice_cout;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (ill_pend_q) begin
          result_d  = '0;
          zero_d    = 1'b1;
          ovf_d     = 1'b0;
          illegal_d = 1'b1;
        end else begin
          result_d  = fin_res;
          zero_d    = (fin_res == '0);
          ovf_d     = is_addsub & ovf_raw_q;
          illegal_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      funct_q    <= '0;
      ovf_raw_q  <= 1'b0;
      ill_pend_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      ovf_q      <= 1'b0;
      illegal_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      funct_q    <= funct_d;
      ovf_raw_q  <= ovf_raw_d;
      ill_pend_q <= ill_pend_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      illegal_q  <= illegal_d;
      done_q     <= done_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign ovf     = ovf_q;
  assign illegal = illegal_q;

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 funct  input  6  R-type function code, captured with start.
REQ-006 a  input  WIDTH  operand A (rs), captured with start.
REQ-007 b  input  WIDTH  operand B (rt), captured with start.
REQ-008 busy  output  1  high while a request is held (RUN or DONE).
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  WIDTH  final result; stable from done until the next accepted start.
REQ-011 zero  output  1  high iff result == 0; valid with done.
REQ-012 ovf  output  1  signed overflow; set only for add/sub, else 0.
REQ-013 illegal  output  1  funct unsupported; valid with done.

Function
REQ-014 Supported funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
REQ-015 Per-op slice control (Ainvert, Binvert, Cin, Op): add 0,0,0,10; sub 0,1,1,10; and 0,0,x,00; or 0,0,x,01; nor 1,1,x,00; slt 0,1,1,10.
REQ-016 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE, start=1, legal funct -> capture a, b, funct into shift registers; bit counter = 0; carry register = Cin of op; -> RUN.
REQ-018 IDLE, start=1, illegal funct -> result=0, illegal=1, ovf=0, zero=1; -> DONE next edge.
REQ-019 RUN: one bit per cycle, LSB first; slice consumes a[i], b[i], carry; result bit shifted in at MSB of result register; carry register takes slice Cout.
REQ-020 RUN lasts exactly WIDTH cycles; on the edge processing bit WIDTH-1 -> DONE.
REQ-021 ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (add/sub only).
REQ-022 slt: result = {WIDTH-1 zeros, less}, less = sum[WIDTH-1] XOR ovf; ovf output forced 0 for slt.
REQ-023 DONE: done=1 for exactly one cycle; -> IDLE next edge.
REQ-024 Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH+1 (legal) or k+1 (illegal).
REQ-025 start while busy: ignored, no effect on in-flight operation.
REQ-026 start in the DONE cycle: ignored; accepted next cycle in IDLE.
REQ-027 Carry out of final bit discarded (modulo 2^WIDTH wrap).
REQ-028 a, b, funct changes during RUN have no effect.

Reset
REQ-029 Reset asserted at any time (incl. mid-RUN) aborts the operation; state -> IDLE immediately.
REQ-030 Reset values: busy=0, done=0, result=0, zero=1, ovf=0, illegal=0; counter, carry, shift registers 0.
REQ-031 First start accepted at first rising edge after reset deasserts.

Structure
REQ-032 Shared package holds funct code constants, FSM state encoding, slice Op codes (00 AND, 01 OR, 10 SUM).
REQ-033 One sub-module: alu_bit_slice (1-bit invert/AND/OR/full-add slice, combinational); instantiated once.
REQ-034 Counter width = clog2(WIDTH)+1; no multi-bit adder in the datapath.

Verification
REQ-035 WIDTH=32, add a=0x7FFFFFFF b=0x00000001 -> result 0x80000000, ovf=1, zero=0, done 33 cycles after start edge.
REQ-036 sub a=5 b=5 -> result 0, zero=1, ovf=0; slt a=0xFFFFFFFF(-1) b=1 -> result 1; slt a=0x80000000 b=1 -> result 1 (overflow corrected).
REQ-037 nor a=0x0F0F0F0F b=0x00FF00FF -> result 0xF000F000; and/or same operands -> 0x000F000F / 0x0FFF0FFF.
REQ-038 funct=0x21 -> done one cycle after start edge, illegal=1, result 0.
REQ-039 start pulsed every cycle during RUN and DONE -> only first accepted; next accepted in IDLE.
REQ-040 reset asserted at bit 10 of an add -> outputs at reset values asynchronously; new add after release completes correctly.
